// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole score keeper.
package mole_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HOLD = 2'd2,
        S_OVER = 2'd3
    } mole_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [4:0] NO_KEY = 5'd16;

    // Two-digit BCD increment without saturation; the caller decides about 99.
    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        bcd_digit_t tens;
        bcd_digit_t units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            units = 4'd0;
            tens  = tens + 4'd1;
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/mole_buzz_timer.sv
// Buzz window down-counter with optional tone divider.
// Optional feature: MOLE_BUZZ_TONE_EN (square-wave tone instead of steady drive).
module mole_buzz_timer #(
    parameter int BUZZ_CYCLES = 5_000_000,
    parameter int TONE_HALF   = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic buzzer
);

    localparam int CW = $clog2(BUZZ_CYCLES + 1);

    if (TONE_HALF < 1) begin : g_bad_tone
        $error("mole_buzz_timer: TONE_HALF must be at least 1");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(BUZZ_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

`ifdef MOLE_BUZZ_TONE_EN
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [TW-1:0] tone_cnt;
    logic          tone;

    // Phase restarts on every load so the first cycle after a hit is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (load) begin
            tone_cnt <= TW'(TONE_HALF - 1);
            tone     <= 1'b1;
        end else if (cnt != '0) begin
            if (tone_cnt == '0) begin
                tone_cnt <= TW'(TONE_HALF - 1);
                tone     <= ~tone;
            end else begin
                tone_cnt <= tone_cnt - 1'b1;
            end
        end
    end

    assign buzzer = (cnt != '0) && tone;
`else
    assign buzzer = (cnt != '0);
`endif

endmodule

// File: rtl/mole_score_keeper.sv
// Whack-a-mole score keeper: press detection, hit/miss scoring, game FSM.
// Build option MOLE_BUZZ_TONE_EN selects a toned buzzer in mole_buzz_timer.
//
// state  | meaning
// IDLE   | after reset, waiting for the first game_start edge
// PLAY   | armed, the next press event is scored as hit or miss
// HOLD   | a press was scored, waiting for the key to be released
// OVER   | miss limit reached, counters frozen until game_start edge
module mole_score_keeper
    import mole_pkg::*;
#(
    parameter int BUZZ_CYCLES = 5_000_000,
    parameter int MISS_LIMIT  = 5,
    parameter int TONE_HALF   = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_code,
    input  logic [7:0] mole_onehot,
    input  logic       game_start,
    output logic [7:0] score_bcd,
    output logic [3:0] miss_cnt,
    output logic       hit_pulse,
    output logic       buzzer,
    output logic       game_over
);

    if (MISS_LIMIT < 1 || MISS_LIMIT > 15) begin : g_bad_limit
        $error("mole_score_keeper: MISS_LIMIT must be in 1..15");
    end

    mole_state_t state, state_d;
    logic [4:0]  key_q;
    logic        gs_q;

    logic [4:0]  key_n;
    logic        press;
    logic        start_edge;
    logic        mole_valid;
    logic        hit_now;
    logic        last_miss;

    logic        do_clear;
    logic        do_hit;
    logic        do_miss;

    assign key_n      = (key_code >= NO_KEY) ? NO_KEY : key_code;
    assign press      = (key_q == NO_KEY) && (key_n != NO_KEY);
    assign start_edge = game_start && !gs_q;
    assign mole_valid = (mole_onehot != 8'd0) &&
                        ((mole_onehot & (mole_onehot - 8'd1)) == 8'd0);
    assign hit_now    = press && (key_n[4:3] == 2'b00) && mole_valid &&
                        mole_onehot[key_n[2:0]];
    assign last_miss  = ({1'b0, miss_cnt} + 5'd1) == 5'(MISS_LIMIT);

    always_comb begin
        state_d  = state;
        do_clear = 1'b0;
        do_hit   = 1'b0;
        do_miss  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_d  = S_PLAY;
                    do_clear = 1'b1;
                end
            end
            S_PLAY: begin
                if (press) begin
                    if (hit_now) begin
                        do_hit  = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        do_miss = 1'b1;
                        state_d = last_miss ? S_OVER : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (key_n == NO_KEY) begin
                    state_d = S_PLAY;
                end
            end
            S_OVER: begin
                if (start_edge) begin
                    state_d  = S_PLAY;
                    do_clear = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            key_q     <= NO_KEY;
            gs_q      <= 1'b0;
            score_bcd <= 8'h00;
            miss_cnt  <= 4'd0;
            hit_pulse <= 1'b0;
        end else begin
            state     <= state_d;
            key_q     <= key_n;
            gs_q      <= game_start;
            hit_pulse <= do_hit;
            if (do_clear) begin
                score_bcd <= 8'h00;
                miss_cnt  <= 4'd0;
            end else begin
                if (do_hit && score_bcd != 8'h99) begin
                    score_bcd <= bcd2_inc(score_bcd);
                end
                if (do_miss) begin
                    miss_cnt <= miss_cnt + 4'd1;
                end
            end
        end
    end

    assign game_over = (state == S_OVER);

    mole_buzz_timer #(
        .BUZZ_CYCLES(BUZZ_CYCLES),
        .TONE_HALF  (TONE_HALF)
    ) u_buzz (
        .clk   (clk),
        .rst   (rst),
        .load  (do_hit),
        .buzzer(buzzer)
    );

endmodule

// File: tb/tb_mole_score_keeper.sv
// Randomized and directed bench for mole_score_keeper against a behavioural game model.
module tb_mole_score_keeper;

    localparam int BUZZ  = 20;
    localparam int LIMIT = 5;
    localparam int THALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] key_code = 5'd16;
    logic [7:0] mole_onehot = 8'h00;
    logic       game_start = 1'b0;
    logic [7:0] score_bcd;
    logic [3:0] miss_cnt;
    logic       hit_pulse;
    logic       buzzer;
    logic       game_over;

    mole_score_keeper #(
        .BUZZ_CYCLES(BUZZ),
        .MISS_LIMIT (LIMIT),
        .TONE_HALF  (THALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .mole_onehot(mole_onehot),
        .game_start (game_start),
        .score_bcd  (score_bcd),
        .miss_cnt   (miss_cnt),
        .hit_pulse  (hit_pulse),
        .buzzer     (buzzer),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Game model: plain decimal score, miss tally, buzz cycles remaining.
    int  m_mode;          // 0 idle, 1 playing/armed, 2 waiting for release, 3 game over
    int  m_score;
    int  m_miss;
    int  m_buzz_left;
    int  m_buzz_elapsed;
    int  m_prev_key;
    bit  m_prev_gs;
    bit  m_hit;

    function automatic logic [7:0] to_bcd(input int s);
        return 8'(((s / 10) << 4) | (s % 10));
    endfunction

    function automatic bit exp_buzzer();
`ifdef MOLE_BUZZ_TONE_EN
        return (m_buzz_left > 0) && (((m_buzz_elapsed / THALF) % 2) == 0);
`else
        return m_buzz_left > 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_miss = 0;
        m_buzz_left = 0; m_buzz_elapsed = 0;
        m_prev_key = 16; m_prev_gs = 1'b0; m_hit = 1'b0;
    endtask

    task automatic model_step();
        int  k;
        bit  pressed;
        bit  sedge;
        bit  is_hit;
        k       = (int'(key_code) > 16) ? 16 : int'(key_code);
        pressed = (m_prev_key == 16) && (k != 16);
        sedge   = game_start && !m_prev_gs;
        is_hit  = pressed && k < 8 && $countones(mole_onehot) == 1 && mole_onehot[k];
        m_hit   = 1'b0;
        case (m_mode)
            0, 3: if (sedge) begin m_mode = 1; m_score = 0; m_miss = 0; end
            1: if (pressed) begin
                if (is_hit) begin
                    m_hit = 1'b1;
                    if (m_score < 99) m_score++;
                    m_mode = 2;
                end else begin
                    m_miss++;
                    m_mode = (m_miss == LIMIT) ? 3 : 2;
                end
            end
            2: if (k == 16) m_mode = 1;
            default: m_mode = 0;
        endcase
        if (m_hit) begin
            m_buzz_left = BUZZ; m_buzz_elapsed = 0;
        end else if (m_buzz_left > 0) begin
            m_buzz_left--; m_buzz_elapsed++;
        end
        m_prev_key = k;
        m_prev_gs  = game_start;
    endtask

    task automatic compare_all();
        chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
        chk("miss", 32'(miss_cnt), 32'(m_miss));
        chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        chk("buzzer", 32'(buzzer), 32'(exp_buzzer()));
        chk("game_over", 32'(game_over), 32'(m_mode == 3));
    endtask

    task automatic tick(input int k, input logic [7:0] m, input logic gs);
        key_code = 5'(k); mole_onehot = m; game_start = gs;
        model_step();
        @(posedge clk); #1;
        compare_all();
    endtask

    task automatic start_game();
        tick(16, mole_onehot, 1'b1);
        tick(16, mole_onehot, 1'b0);
    endtask

    task automatic press_release(input int k, input logic [7:0] m);
        tick(k, m, 1'b0);
        tick(k, m, 1'b0);
        tick(16, m, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1; key_code = 5'd16; game_start = 1'b0;
        #1;
        chk("rst_buzzer", 32'(buzzer), 32'd0);
        chk("rst_hit", 32'(hit_pulse), 32'd0);
        chk("rst_over", 32'(game_over), 32'd0);
        chk("rst_score", 32'(score_bcd), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Single hit: one pulse, score 01, buzzer for exactly BUZZ cycles.
        start_game();
        tick(16, 8'b0000_0100, 1'b0);
        tick(2, 8'b0000_0100, 1'b0);
        chk("first_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("first_hit_score", 32'(score_bcd), 32'h01);
        for (int i = 0; i < BUZZ + 4; i++) tick((i < 3) ? 2 : 16, 8'b0000_0100, 1'b0);

        // Key held at 3 while the mole moves onto bit 3: no rescoring.
        tick(3, 8'b0000_0001, 1'b0);
        for (int i = 0; i < 4; i++) tick(3, 8'b0000_1000, 1'b0);
        chk("held_no_rescore", 32'(score_bcd), 32'h01);
        tick(16, 8'b0000_1000, 1'b0);
        tick(3, 8'b0000_1000, 1'b0);
        chk("repress_hit", 32'(score_bcd), 32'h02);
        tick(16, 8'b0000_1000, 1'b0);

        // Miss misses until game over; later presses and starts-in-play ignored.
        tick(16, 8'b0000_0010, 1'b1);
        for (int i = 0; i < LIMIT; i++) press_release(5, 8'b0000_0010);
        chk("miss_limit", 32'(miss_cnt), 32'(LIMIT));
        chk("over_flag", 32'(game_over), 32'd1);
        press_release(1, 8'b0000_0010);
        chk("over_frozen", 32'(score_bcd), 32'h02);

        // BCD carry and saturation.
        tick(16, 8'b0000_0001, 1'b0);
        start_game();
        for (int i = 0; i < 9; i++) press_release(0, 8'b0000_0001);
        chk("bcd_09", 32'(score_bcd), 32'h09);
        press_release(0, 8'b0000_0001);
        chk("bcd_10", 32'(score_bcd), 32'h10);
        for (int i = 0; i < 89; i++) press_release(0, 8'b0000_0001);
        chk("bcd_99", 32'(score_bcd), 32'h99);
        tick(0, 8'b0000_0001, 1'b0);
        chk("sat_hit_pulse", 32'(hit_pulse), 32'd1);
        chk("sat_score", 32'(score_bcd), 32'h99);
        tick(16, 8'b0000_0001, 1'b0);

        // Multi-hot and empty moles always miss.
        press_release(0, 8'b0000_0011);
        press_release(0, 8'b0000_0000);

        // Reset during an active buzz window.
        press_release(0, 8'b0000_0001);
        tick(16, 8'b0000_0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midbuzz_buzzer", 32'(buzzer), 32'd0);
        chk("midbuzz_score", 32'(score_bcd), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(16, 8'b0000_0001, 1'b0);
        tick(0, 8'b0000_0001, 1'b0);
        chk("idle_no_score", 32'(score_bcd), 32'd0);
        tick(16, 8'b0000_0001, 1'b0);

        // Randomized play.
        begin
            int k = 16;
            logic [7:0] m = 8'h01;
            for (int i = 0; i < 4000; i++) begin
                int r = $urandom_range(0, 9);
                if (r < 5) k = 16;
                else if (r < 7) k = k;
                else k = $urandom_range(0, 31);
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 3) == 0) m = 8'($urandom());
                    else m = 8'(1 << $urandom_range(0, 7));
                end
                tick(k, m, ($urandom_range(0, 29) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
